instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word address of the first fetch after reset.
REQ-002 Parameter: BUF_DEPTH, 2, entries in the fetched-instruction buffer (power of two, 2..4).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 redirect_valid  input  1  branch unit requests a PC change this cycle.
REQ-006 redirect_addr  input  32  new fetch word address; valid with redirect_valid.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word address of the current request.
REQ-009 imem_ack  input  1  memory returns data for the outstanding request this cycle.
REQ-010 imem_rdata  input  32  instruction word; valid with imem_ack.
REQ-011 inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 inst_ready  input  1  decode accepts the head this cycle.
REQ-013 inst_word  output  32  head instruction word.
REQ-014 inst_pc  output  32  word address of the head instruction.
REQ-015 inst_pc_next  output  32  inst_pc + 1, modulo 2^32.

Function
REQ-016 PC arithmetic SHALL be word-granular: the sequential fetch address is the previous fetch address + 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-017 The FSM SHALL have three states: FETCH (request may be issued), DROP (stale request outstanding; its data is discarded), HOLD (no request; buffer slots exhausted).
REQ-018 Request handshake: once imem_req rises, imem_req and imem_addr SHALL stay stable until the cycle imem_ack is high; ack in the same cycle as req (zero wait) SHALL be supported.
REQ-019 imem_ack while imem_req is low SHALL be ignored.
REQ-020 A request SHALL be issued only if (buffered entries + outstanding requests) < BUF_DEPTH; otherwise the FSM enters HOLD and returns to FETCH the cycle after a slot frees.
REQ-021 On ack in FETCH, {imem_addr, imem_rdata} SHALL be written to the buffer tail and the fetch address SHALL advance by 1; a new request MAY be issued the following cycle.
REQ-022 Buffer output SHALL be first-word-fall-through: inst_valid is high whenever the buffer is non-empty, with no combinational path from imem_rdata to inst_word.
REQ-023 A pop occurs when inst_valid and inst_ready are both high; push and pop in the same cycle SHALL both take effect, and occupancy SHALL stay unchanged.
REQ-024 Fetch-to-inst_valid latency SHALL be one cycle after the ack edge.
REQ-025 On redirect_valid, the buffer SHALL be flushed, and the fetch address SHALL be set to redirect_addr at the next edge.
REQ-026 Redirect with no request outstanding: the next request SHALL use redirect_addr.
REQ-027 Redirect with a request outstanding and imem_ack high in the same cycle: the returned data SHALL be discarded, and the FSM SHALL remain in FETCH.
REQ-028 Redirect with a request outstanding and no ack: the FSM SHALL enter DROP and keep the old request stable until ack.
REQ-029 In DROP, the acked data SHALL be discarded, and the FSM SHALL then return to FETCH, issuing redirect_addr.
REQ-030 A further redirect while in DROP SHALL replace the pending target; the last redirect wins.
REQ-031 Redirect and pop in the same cycle: the pop SHALL be considered consumed, and the flush SHALL take priority for all remaining entries.
REQ-032 The buffer occupancy counter SHALL never exceed BUF_DEPTH or underflow below 0.

Reset
REQ-033 While rst is low, the block SHALL hold these values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_word=0, inst_pc=0, inst_pc_next=1, buffer empty, FSM state FETCH, fetch address RESET_PC.
REQ-034 Reset asserted mid-request SHALL abandon the request; a late ack after reset release and before the first new request SHALL be ignored.
REQ-035 The first request SHALL be issued in the first cycle after rst deasserts.

Verification
REQ-036 Zero-wait memory, inst_ready=1, RESET_PC=0 -> inst_pc sequence 0,1,2,3 on consecutive cycles after the first fill, inst_pc_next = inst_pc+1.
REQ-037 inst_ready=0 for 10 cycles -> exactly BUF_DEPTH entries buffered, imem_req low (HOLD); raise inst_ready -> entries drain in order, fetching resumes.
REQ-038 Request at addr 5 with ack delayed 3 cycles, redirect_addr=0x40 in the first wait cycle -> addr 5 held until ack, its data is not delivered, and the next request and delivered inst_pc are 0x40.
REQ-039 Redirect to 0x80 coinciding with an ack of addr 7 and a pop -> addr 7 data is dropped, the buffer is empty next cycle, and the next inst_pc is 0x80.
REQ-040 Wrap: redirect to 32'hFFFF_FFFF -> inst_pc FFFF_FFFF with inst_pc_next 0, and the following inst_pc is 0.
REQ-041 Assert rst low during an outstanding request -> all outputs go to their reset values immediately (no clock edge required), and after release the first request is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-addressed instruction-memory reads,
// buffers returned words in a small first-word-fall-through queue and
// handles branch redirects, including requests still in flight.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   redirect_valid, redirect_addr  branch-unit PC change
//   imem_req, imem_addr            memory read request (held until ack)
//   imem_ack, imem_rdata           memory response
//   inst_valid, inst_ready         decode handshake on the buffer head
//   inst_word, inst_pc             head instruction and its word address
//   inst_pc_next                   inst_pc + 1 (wrapping)
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_next
);

    localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic            req_q, req_n;
    logic [31:0]     req_addr_q;
    logic [31:0]     fetch_addr_q, fetch_addr_n;
    logic [CW-1:0]   count_q, count_n;
    logic [AW-1:0]   head_q, tail_q;
    logic [31:0]     buf_word [BUF_DEPTH];
    logic [31:0]     buf_pc   [BUF_DEPTH];

    logic            wait_c;
    logic            push_c;
    logic            pop_c;
    logic            issue_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_n;
    end

    // Next-state and request decision; a new request needs a free slot after this edge
    always_comb begin
        state_n = state_q;
        req_n   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (wait_c) begin
                    req_n = 1'b1;
                    if (redirect_valid) state_n = DROP;
                end else if (count_n < DEPTH_C) begin
                    req_n = 1'b1;
                end else begin
                    state_n = HOLD;
                end
            end
            DROP: begin
                // Buffer is empty here, so the redirect target can go out right after the ack
                req_n = 1'b1;
                if (!wait_c) state_n = FETCH;
            end
            HOLD: begin
                if (count_n < DEPTH_C) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Datapath strobes and next occupancy / fetch address
    always_comb begin
        wait_c       = req_q & ~imem_ack;
        push_c       = req_q & imem_ack & (state_q == FETCH) & ~redirect_valid;
        pop_c        = inst_valid & inst_ready;
        issue_c      = req_n & ~wait_c;
        count_n      = count_q;
        fetch_addr_n = fetch_addr_q;
        if (redirect_valid) begin
            count_n      = '0;
            fetch_addr_n = redirect_addr;
        end else begin
            count_n = count_q + CW'(push_c) - CW'(pop_c);
            if (push_c) fetch_addr_n = fetch_addr_q + 32'd1;
        end
    end

    // Request, address and buffer storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q        <= 1'b0;
            req_addr_q   <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_word[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            req_q        <= req_n;
            fetch_addr_q <= fetch_addr_n;
            count_q      <= count_n;
            if (issue_c) req_addr_q <= fetch_addr_n;
            if (redirect_valid) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (push_c) begin
                    buf_word[tail_q] <= imem_rdata;
                    buf_pc[tail_q]   <= req_addr_q;
                    tail_q           <= tail_q + AW'(1);
                end
                if (pop_c) head_q <= head_q + AW'(1);
            end
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = req_addr_q;
    assign inst_valid   = (count_q != '0);
    assign inst_word    = buf_word[head_q];
    assign inst_pc      = buf_pc[head_q];
    assign inst_pc_next = buf_pc[head_q] + 32'd1;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory and decode stimulus with a queue-based
// model of the instruction stream the decoder should receive.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_next;

    instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_pc(inst_pc), .inst_pc_next(inst_pc_next)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: PCs the decoder should see, next fetch address, stale-request flag
    logic [31:0] q[$];
    logic [31:0] m_fetch;
    bit          stale;
    bit          prev_pend;
    logic [31:0] prev_addr;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fetch   = RST_PC;
        stale     = 1'b0;
        prev_pend = 1'b0;
        prev_addr = '0;
    endtask

    task automatic drive(input bit ack_b, input bit rdr, input logic [31:0] raddr, input bit rdy);
        imem_ack       = ack_b;
        imem_rdata     = imem_req ? fmem(imem_addr) : $urandom;
        redirect_valid = rdr;
        redirect_addr  = rdr ? raddr : $urandom;
        inst_ready     = rdy;
    endtask

    // Compare this cycle's outputs with the model, then apply this cycle's events
    task automatic observe();
        logic [31:0] hpc;
        bit ack_v;
        check_eq("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            hpc = q[0];
            check_eq("inst_pc", inst_pc, hpc);
            check_eq("inst_word", inst_word, fmem(hpc));
            check_eq("inst_pc_next", inst_pc_next, hpc + 32'd1);
        end
        if (prev_pend) begin
            check_eq("req_hold", 32'(imem_req), 32'd1);
            check_eq("addr_hold", imem_addr, prev_addr);
        end else if (imem_req) begin
            check_eq("req_addr", imem_addr, m_fetch);
            check_eq("req_slot", 32'(q.size() < int'(DEPTH)), 32'd1);
            check_eq("req_stale", 32'(stale), 32'd0);
        end
        ack_v = imem_req && imem_ack;
        if (q.size() != 0 && inst_ready) void'(q.pop_front());
        if (ack_v) begin
            if (!stale && !redirect_valid) begin
                q.push_back(imem_addr);
                m_fetch = imem_addr + 32'd1;
            end
            stale = 1'b0;
        end
        if (redirect_valid) begin
            q.delete();
            m_fetch = redirect_addr;
            if (imem_req && !imem_ack) stale = 1'b1;
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
    endtask

    task automatic cycle(input bit ack_b, input bit rdr, input logic [31:0] raddr, input bit rdy);
        @(posedge clk);
        #1;
        drive(ack_b, rdr, raddr, rdy);
        @(negedge clk);
        observe();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
        check_eq({tag, "_addr"}, imem_addr, RST_PC);
        check_eq({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check_eq({tag, "_word"}, inst_word, 32'd0);
        check_eq({tag, "_pc"}, inst_pc, 32'd0);
        check_eq({tag, "_pcn"}, inst_pc_next, 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst0");
        #10 rst = 1'b1;

        // Zero-wait memory, decoder always ready: back-to-back PCs
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            if (i >= 2) check_eq("seq_pc", inst_pc, 32'(i - 2));
        end

        // Decoder stalls: buffer fills and requests stop
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        check_eq("stall_req", 32'(imem_req), 32'd0);
        check_eq("stall_valid", 32'(inst_valid), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            seen = imem_req;
        end
        check_eq("resume_req", 32'(seen), 32'd1);

        // Redirect while a request waits for its ack
        cycle(1'b1, 1'b1, 32'd5, 1'b1);
        cycle(1'b0, 1'b1, 32'h40, 1'b1);
        check_eq("drop_addr0", imem_addr, 32'd5);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_eq("drop_addr1", imem_addr, 32'd5);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_eq("drop_new_addr", imem_addr, 32'h40);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_eq("drop_pc", inst_pc, 32'h40);

        // Redirect coinciding with an ack and a pop
        cycle(1'b1, 1'b1, 32'd5, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h80, 1'b1);
        check_eq("coll_addr", imem_addr, 32'd7);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_eq("coll_empty", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_eq("coll_pc", inst_pc, 32'h80);

        // Address wrap
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_eq("wrap_pc", inst_pc, 32'hFFFF_FFFF);
        check_eq("wrap_pcn", inst_pc_next, 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_eq("wrap_pc0", inst_pc, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 2)) : $urandom;
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ra,
                  ($urandom_range(0, 3) != 0));
        end

        // Reset during an outstanding request
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_eq("pre_rst_req", 32'(imem_req), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst1");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        imem_ack       = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", imem_addr, RST_PC);
        drive(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        observe();
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), $urandom,
                  ($urandom_range(0, 3) != 0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
